// File: rtl/filter_pkg.sv
// Shared constants and host FSM encoding for the stereo FIR coefficient controller.
package filter_pkg;

  localparam int PTR   = 9;
  localparam int WIDTH = 16;
  localparam int TAPS  = 2 ** PTR;

  localparam int ST_IDLE_BIT    = 0;
  localparam int ST_GRANT_BIT   = 1;
  localparam int ST_RD_WAIT_BIT = 2;
  localparam int ST_ACK_BIT     = 3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_GRANT   = 4'b0010,
    ST_RD_WAIT = 4'b0100,
    ST_ACK     = 4'b1000
  } host_st_e;

endpackage

// File: rtl/filter_coeff_swap.sv
// Active/shadow bank swap control: latches a host swap request and applies it
// only while the filter and the host port are both quiet.
module filter_coeff_swap (
  input  logic clk,
  input  logic rstb,
  input  logic swap_req_i,
  input  logic filt_busy_i,
  input  logic filt_re_i,
  input  logic fsm_idle_i,
  output logic swap_apply_o,
  output logic swap_pending_o,
  output logic active_bank_o
);

  logic pending_q, pending_d;
  logic bank_q, bank_d;

  // Apply looks only at the registered pending flag, so a request can never
  // take effect on the edge that records it.
  assign swap_apply_o = pending_q & ~filt_busy_i & ~filt_re_i & fsm_idle_i;

  always_comb begin
    pending_d = pending_q;
    bank_d    = bank_q;
    if (swap_apply_o) begin
      pending_d = 1'b0;
      bank_d    = ~bank_q;
    end else if (swap_req_i) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      bank_q    <= bank_d;
    end
  end

  assign swap_pending_o = pending_q;
  assign active_bank_o  = bank_q;

endmodule

// File: rtl/filter_coeff_ctrl.sv
// Coefficient RAM controller: filter reads hit the active bank, host accesses the shadow bank.
// Optional FILTER_COEFF_CSUM_EN adds a running checksum of acknowledged host writes.
module filter_coeff_ctrl
  import filter_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               host_req,
  input  logic               host_wr,
  input  logic [PTR-1:0]     host_addr,
  input  logic [WIDTH-1:0]   host_wdata,
  output logic               host_ack,
  output logic [WIDTH-1:0]   host_rdata,
  input  logic               swap_req,
  output logic               swap_pending,
  output logic               active_bank,
  input  logic               filt_re,
  input  logic [PTR-1:0]     filt_rdptr,
  input  logic               filt_busy,
  output logic [WIDTH-1:0]   filt_coeff,
  output logic               filt_coeff_vld,
  output logic               ram_en,
  output logic               ram_we,
  output logic [PTR:0]       ram_addr,
  output logic [WIDTH-1:0]   ram_wdata,
  input  logic [WIDTH-1:0]   ram_rdata
`ifdef FILTER_COEFF_CSUM_EN
  ,
  output logic [WIDTH+PTR-1:0] coeff_csum
`endif
);

  host_st_e state_q;
  logic     host_go_s;
  logic     swap_apply_s;

  filter_coeff_swap u_swap (
    .clk           (clk),
    .rstb          (rstb),
    .swap_req_i    (swap_req),
    .filt_busy_i   (filt_busy),
    .filt_re_i     (filt_re),
    .fsm_idle_i    (state_q[ST_IDLE_BIT]),
    .swap_apply_o  (swap_apply_s),
    .swap_pending_o(swap_pending),
    .active_bank_o (active_bank)
  );

  // Single RAM port: the filter always wins, the host only uses cycles it leaves free.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    host_go_s = 1'b0;
    if (filt_re) begin
      ram_en   = 1'b1;
      ram_addr = {active_bank, filt_rdptr};
    end else if (state_q[ST_GRANT_BIT]) begin
      host_go_s = 1'b1;
      ram_en    = 1'b1;
      ram_we    = host_wr;
      ram_addr  = {~active_bank, host_addr};
      ram_wdata = host_wdata;
    end else begin
      ram_en = 1'b0;
    end
  end

  // Host handshake FSM; a GRANT pre-empted by the filter simply retries next cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (host_req && !filt_re) state_q <= ST_GRANT;
        end
        ST_GRANT: begin
          if (!filt_re) begin
            if (host_wr) begin
              state_q  <= ST_ACK;
              host_ack <= 1'b1;
            end else begin
              state_q <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          host_rdata <= ram_rdata;
          host_ack   <= 1'b1;
          state_q    <= ST_ACK;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      filt_coeff_vld <= 1'b0;
    end else begin
      filt_coeff_vld <= filt_re;
    end
  end

  // Gated so the multiplier input is quiet whenever no tap read is in flight.
  assign filt_coeff = filt_coeff_vld ? ram_rdata : '0;

`ifdef FILTER_COEFF_CSUM_EN
  logic [WIDTH+PTR-1:0] csum_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      csum_q <= '0;
    end else if (swap_apply_s) begin
      csum_q <= '0;
    end else if (host_go_s && host_wr) begin
      csum_q <= csum_q + {{PTR{1'b0}}, host_wdata};
    end else begin
      csum_q <= csum_q;
    end
  end

  assign coeff_csum = csum_q;
`else
  logic unused_apply_s;
  assign unused_apply_s = swap_apply_s & host_go_s;
`endif

endmodule

// File: doc/filter_coeff_ctrl.md
Name: filter_coeff_ctrl

Overview:
Coefficient-memory controller for the 512-tap stereo FIR. It owns one single-port 2*TAPS x WIDTH coefficient RAM, split into an active bank and a shadow bank.
- Filter tap reads always go to the active bank.
- Register-file host reads and writes always go to the shadow bank.
- A host-requested bank swap is applied only while the filter is idle, so a new coefficient set never takes effect mid-convolution.

Parameters:
PTR, 9, tap address width
WIDTH, 16, coefficient width
TAPS, 512, taps per bank (2**PTR)

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
host_req  in  1  host access request; held until host_ack
host_wr  in  1  1=write, 0=read; valid with host_req
host_addr  in  PTR  tap index in shadow bank
host_wdata  in  WIDTH  write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  WIDTH  read data; valid when host_ack and read
swap_req  in  1  one-cycle pulse: make shadow bank active
swap_pending  out  1  swap requested, not yet applied
active_bank  out  1  current active bank
filt_re  in  1  filter tap read enable
filt_rdptr  in  PTR  filter tap index
filt_busy  in  1  filter in transfer/multiply sequence
filt_coeff  out  WIDTH  coefficient to multipliers (rf_filter_coeff)
filt_coeff_vld  out  1  filt_coeff valid
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  PTR+1  {bank, index}
ram_wdata  out  WIDTH  RAM write data
ram_rdata  in  WIDTH  RAM read data, 1-cycle latency

Behaviour:
- Reset values: all outputs 0; active_bank=0; FSM in IDLE; swap_pending=0.
- Port arbitration, per cycle, fixed priority:
  - filt_re=1: ram_en=1, ram_we=0, ram_addr={active_bank,filt_rdptr}.
  - Otherwise, if FSM grants the host: ram_en=1, ram_addr={~active_bank,host_addr}, ram_we=host_wr, ram_wdata=host_wdata.
  - Otherwise ram_en=0.
- Filter path latency: filt_coeff = ram_rdata registered 0 cycles (pass-through). filt_coeff_vld = filt_re delayed by 1 cycle. Consecutive filt_re cycles give back-to-back coefficients with no bubble.
- Host FSM (one-hot: IDLE, GRANT, RD_WAIT, ACK):
  - IDLE: host_req & ~filt_re -> GRANT.
  - GRANT: RAM access issued this cycle.
    - Write -> ACK.
    - Read -> RD_WAIT.
    - If filt_re rose in the same cycle, the filter wins; stay in GRANT and reissue next free cycle.
  - RD_WAIT: capture ram_rdata into host_rdata -> ACK.
  - ACK: host_ack=1 for exactly one cycle -> IDLE. host_req is ignored in ACK, so a new request needs at least one IDLE cycle.
  - host_rdata holds its value until the next read completes.
- Host starvation is bounded: the filter reads at most TAPS consecutive cycles, then drops filt_re for at least one cycle.
- Swap:
  - swap_req sets swap_pending.
  - Applied on the first cycle with swap_pending & ~filt_busy & ~filt_re & FSM in IDLE: active_bank toggles and swap_pending clears on that same edge.
  - swap_req while already pending: no additional effect (single toggle).
  - swap_req and an apply condition in the same cycle: swap applies on the next qualifying cycle, never on the request edge itself.
- Wrap-around: host_addr and filt_rdptr are PTR bits and wrap naturally. Banks never alias: the bank bit is the MSB of ram_addr.
- Reset mid-operation: any outstanding host access is dropped (no ack), pending swap lost, active_bank returns to 0. RAM contents are not cleared.

Optional Feature:
FILTER_COEFF_CSUM_EN
- Enabled: adds output coeff_csum[WIDTH+PTR-1:0], a running sum of host_wdata over acknowledged host writes.
  - Cleared at reset and on each applied swap.
  - Lets firmware verify a shadow-bank load before requesting a swap.
- Disabled: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package filter_pkg holds PTR, WIDTH, TAPS and the host FSM state encodings with their bit indices, reused by filter_stm.
- One sub-module is natural: filter_coeff_swap (swap_pending/active_bank logic) kept separate from the arbitration FSM.

Test Plan:
1. Reset, then host write addr=5 data=0x1234, then host read addr=5 -> write ack 2 cycles after req; read ack 3 cycles after req with host_rdata=0x1234; ram_addr=0x205 (shadow bank 1).
2. filt_re held 512 cycles with host_req asserted -> host_ack only after filt_re falls; filt_coeff_vld high 512 consecutive cycles; no ram_addr ever in bank 1 during filt_re.
3. Load bank 1 taps 0..511 = index value, swap_req with filt_busy=0 -> active_bank=1, swap_pending=0; filter read filt_rdptr=100 -> filt_coeff=100 next cycle.
4. swap_req while filt_busy=1 for 600 cycles -> swap_pending=1 throughout, active_bank unchanged; toggles one cycle after filt_busy falls.
5. Two swap_req pulses before apply -> active_bank toggles exactly once.
6. rstb low during RD_WAIT with swap_pending=1 -> no host_ack; all outputs 0, active_bank=0 after release. With FILTER_COEFF_CSUM_EN: writes 0x0001 and 0x0002 give coeff_csum=3, cleared to 0 after swap.
